irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Wishbone-slave interrupt controller that replaces the hard-wired OR/priority mux in front of the CPU. It collects up to `N_SRC` device interrupt lines (RAM, disk, VRAM, keyboard, counter, switch), synchronises them, latches them per source as edge- or level-triggered, and applies a software mask. It drives the single `CPU_INT` line and a `CPU_CAUSE` code to `Muliti_CPU`. It occupies one slave slot on `WB_intercon`.

## Interface
- `N_SRC`, default 6: number of interrupt sources, range 1..32.
- `SYNC_STAGES`, default 2: synchroniser depth per source, at least 2.
- `clk`  in  1: bus clock (clk100).
- `rstn`  in  1: reset, asynchronous and active-low.
- `src_irq`  in  N_SRC: asynchronous device request lines, active-high; bit 0 is RAM, bit 5 is switch.
- `STB`  in  1: Wishbone strobe from the intercon.
- `WE`  in  1: write enable; 1 means write.
- `ADDR`  in  32: slave address; only `ADDR[3:2]` is decoded.
- `DAT_I`  in  32: write data.
- `DAT_O`  out  32: read data, valid while `ACK`=1 and 0 otherwise.
- `ACK`  out  1: single-cycle acknowledge.
- `CPU_INT`  out  1: registered interrupt request to the CPU.
- `CPU_CAUSE`  out  32: registered cause code, equal to the winning source index.

## Operation
- Register map, selected by `ADDR[3:2]`:
  - 0 PEND: read returns pending bits; write-1-to-clear, applied to edge-mode bits only.
  - 1 MASK: read/write; 1 enables the source.
  - 2 MODE: read/write; 1 selects edge mode, 0 selects level mode.
  - 3 CAUSE: read-only; returns the current `CPU_CAUSE`, or 0xFFFF_FFFF when no source is active.
- Bits at or above `N_SRC` read 0 and ignore writes.
- Per source, `s` is the synchronised level and `p` is the previous value of `s`.
  - Edge mode: `pend` sets on `s & ~p`. It clears only by a PEND write-1.
  - Level mode: `pend` is loaded with `s` every cycle.
- Active set is `pend & MASK`.
  - `CPU_INT` next value is `|active`.
  - `CPU_CAUSE` next value is the lowest set index in `active`, or 0 when `active` is empty.
  - Lowest index has highest priority.
- Bus handshake FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE → ACK when `STB`=1. Read data is captured, and any write is committed, on this edge.
  - ACK → WAIT_LOW unconditionally. `ACK`=1 in this state only.
  - WAIT_LOW → IDLE when `STB`=0. This prevents a CPU that holds `STB` across its multi-cycle state from getting a double access.
- Writes take effect on the IDLE→ACK edge.

## Timing
- Reset values:
  - `pend`, `MASK`, `MODE`, and the synchronisers reset to 0.
  - `CPU_INT`=0, `CPU_CAUSE`=0, `ACK`=0, `DAT_O`=0; FSM resets to IDLE.
- Latency from a `src_irq` rise to `CPU_INT`: `SYNC_STAGES`+2 rising edges, counting the first sampling edge (4 edges with the default).
- Latency from a MASK write or PEND clear to `CPU_INT` change: the edge after the write edge.
- `ACK` rises 1 cycle after `STB` is first sampled high and lasts exactly 1 cycle.
- Minimum access spacing is 3 cycles.
- Boundary rules:
  - Edge detect and a PEND write-1 on the same bit in the same cycle: set wins, and `pend` stays 1.
  - MODE change from edge to level: `pend` reloads from `s` the next cycle.
  - MODE change from level to edge: `pend` holds its value until cleared.
  - Multiple simultaneous edges: all latch; `CPU_CAUSE` reports the lowest index. After that bit is cleared, the next index appears one cycle later.
  - Masked pending bits stay pending and fire when unmasked.
  - `rstn` asserted mid-access: `ACK` drops immediately (asynchronously), FSM returns to IDLE, and no partial write is kept.
  - `STB` deasserted while in ACK: the FSM still passes through WAIT_LOW, then returns to IDLE.

## Structure
- Shared package `irq_ctrl_pkg` holds:
  - register offsets `REG_PEND`, `REG_MASK`, `REG_MODE`, `REG_CAUSE`;
  - `NO_CAUSE` = 32'hFFFF_FFFF;
  - the FSM state encoding;
  - the cause constants (RAM=0 … SWITCH=5) now hard-coded at top level.
- Sub-module `irq_sync_edge`: one per source, generated. It contains the `SYNC_STAGES` flop chain, the `p` register, and the rising-edge output; reset is `rstn`.
- The priority encoder is a function in the package.

## Test plan
- Reset: hold `rstn`=0 with `src_irq`=6'h3F → `CPU_INT`=0, `ACK`=0, PEND/MASK/MODE read 0 after release.
- Edge latch and latency:
  - Setup: MASK=0x3F, MODE=0x20; pulse `src_irq[5]` for 3 cycles.
  - Expected: `CPU_INT`=1 exactly 4 edges after the rise, `CPU_CAUSE`=5.
  - Stays set after the pulse ends; writing PEND=0x20 clears it, and `CPU_INT`=0 one edge after the write.
- Priority:
  - Setup: level mode, MASK=0x3F; raise `src_irq`=6'h18.
  - Expected: `CPU_CAUSE`=3 and CAUSE reads 3; dropping bit 3 → `CPU_CAUSE`=4.
  - With MASK=0x00, CAUSE reads 0xFFFF_FFFF.
- Set/clear collision: in edge mode, a rising edge on bit 0 coincides with a PEND write of 0x01 → PEND reads 0x01 afterwards.
- Held STB: hold `STB`=1, `WE`=1, MASK write of 0x15 for 10 cycles → exactly one `ACK` pulse, one write; MASK reads 0x15. `ACK` re-pulses only after `STB` has been low for 1 cycle.
- Reset mid-access: assert `rstn`=0 in the cycle `STB` rises with a MASK write of 0x3F → `ACK` never pulses, MASK reads 0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared register map, bus FSM encoding and priority encoder for irq_ctrl
package irq_ctrl_pkg;

    localparam logic [1:0] REG_PEND  = 2'd0;
    localparam logic [1:0] REG_MASK  = 2'd1;
    localparam logic [1:0] REG_MODE  = 2'd2;
    localparam logic [1:0] REG_CAUSE = 2'd3;

    localparam logic [31:0] NO_CAUSE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } bus_state_e;

    // Source numbering seen by software in CPU_CAUSE.
    typedef enum logic [4:0] {
        SRC_RAM     = 5'd0,
        SRC_DISK    = 5'd1,
        SRC_VRAM    = 5'd2,
        SRC_KBD     = 5'd3,
        SRC_COUNTER = 5'd4,
        SRC_SWITCH  = 5'd5
    } irq_src_e;

    // Lowest set bit wins; an empty vector encodes as 0.
    function automatic logic [31:0] lowest_index(input logic [31:0] vec);
        logic [31:0] idx;
        idx = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// rtl/irq_ctrl_sync_edge.sv - per-source synchroniser chain with rising-edge detect
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - Wishbone-slave interrupt controller with per-source edge/level latching and masking
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             STB,
    input  logic             WE,
    input  logic [31:0]      ADDR,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    output logic             ACK,
    output logic             CPU_INT,
    output logic [31:0]      CPU_CAUSE
);

    bus_state_e       state;
    logic [N_SRC-1:0] s_lvl, s_rise;
    logic [N_SRC-1:0] pend_q, mask_q, mode_q;
    logic [N_SRC-1:0] pend_clr, pend_next, active;
    logic [N_SRC-1:0] wr_data;
    logic [1:0]       reg_sel;
    logic             bus_go, wr_go;
    logic [31:0]      rd_data;
    logic             unused_bus;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rstn     (rstn),
            .async_in (src_irq[i]),
            .level    (s_lvl[i]),
            .rise     (s_rise[i])
        );
    end

    assign reg_sel    = ADDR[3:2];
    assign wr_data    = DAT_I[N_SRC-1:0];
    assign bus_go     = (state == ST_IDLE) && STB;
    assign wr_go      = bus_go && WE;
    assign unused_bus = ^{ADDR[31:4], ADDR[1:0], DAT_I};

    // A new edge beats a same-cycle software clear so no request is lost.
    assign pend_clr  = (wr_go && reg_sel == REG_PEND) ? wr_data : '0;
    assign pend_next = (mode_q & ((pend_q & ~pend_clr) | s_rise)) | (~mode_q & s_lvl);
    assign active    = pend_q & mask_q;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_PEND:  rd_data = 32'(pend_q);
            REG_MASK:  rd_data = 32'(mask_q);
            REG_MODE:  rd_data = 32'(mode_q);
            REG_CAUSE: rd_data = CPU_INT ? CPU_CAUSE : NO_CAUSE;
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q    <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            CPU_INT   <= 1'b0;
            CPU_CAUSE <= '0;
        end else begin
            pend_q    <= pend_next;
            CPU_INT   <= |active;
            CPU_CAUSE <= lowest_index(32'(active));
            if (wr_go && reg_sel == REG_MASK) mask_q <= wr_data;
            if (wr_go && reg_sel == REG_MODE) mode_q <= wr_data;
        end
    end

    // WAIT_LOW absorbs a strobe held across a multi-cycle CPU state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            ACK   <= 1'b0;
            DAT_O <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (STB) begin
                        state <= ST_ACK;
                        ACK   <= 1'b1;
                        DAT_O <= rd_data;
                    end
                end
                ST_ACK: begin
                    state <= ST_WAIT_LOW;
                    ACK   <= 1'b0;
                    DAT_O <= '0;
                end
                ST_WAIT_LOW: begin
                    if (!STB) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    ACK   <= 1'b0;
                    DAT_O <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl against a cycle-level behavioural model
module tb_irq_ctrl;

    localparam int N    = 6;
    localparam int SYNC = 2;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic [N-1:0]  src_irq = '0;
    logic          STB     = 1'b0;
    logic          WE      = 1'b0;
    logic [31:0]   ADDR    = '0;
    logic [31:0]   DAT_I   = '0;
    logic [31:0]   DAT_O;
    logic          ACK;
    logic          CPU_INT;
    logic [31:0]   CPU_CAUSE;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .src_irq   (src_irq),
        .STB       (STB),
        .WE        (WE),
        .ADDR      (ADDR),
        .DAT_I     (DAT_I),
        .DAT_O     (DAT_O),
        .ACK       (ACK),
        .CPU_INT   (CPU_INT),
        .CPU_CAUSE (CPU_CAUSE)
    );

    // Write notification from the stimulus side: valid for the edge that commits it.
    logic         mdl_wr = 1'b0;
    logic [1:0]   mdl_wa = '0;
    logic [31:0]  mdl_wd = '0;

    // Reference state: sampled source history, registers, and the outputs they imply.
    logic [N-1:0] hist [0:SYNC] = '{default: '0};
    logic [N-1:0] m_pend = '0, m_mask = '0, m_mode = '0;
    logic         m_int = 1'b0;
    logic [31:0]  m_cause = '0;

    always @(posedge clk or negedge rstn) begin : model
        logic [N-1:0] s, p, act, clr;
        logic found;
        if (!rstn) begin
            for (int k = 0; k <= SYNC; k++) hist[k] = '0;
            m_pend = '0; m_mask = '0; m_mode = '0; m_int = 1'b0; m_cause = '0;
        end else begin
            act   = m_pend & m_mask;
            m_int = (act != '0);
            m_cause = 32'd0;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (act[i] && !found) begin
                    m_cause = 32'(i);
                    found = 1'b1;
                end
            end
            s   = hist[SYNC-1];
            p   = hist[SYNC];
            clr = (mdl_wr && mdl_wa == 2'd0) ? mdl_wd[N-1:0] : '0;
            for (int i = 0; i < N; i++) begin
                if (m_mode[i]) begin
                    if (s[i] && !p[i]) m_pend[i] = 1'b1;
                    else if (clr[i])   m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = s[i];
                end
            end
            if (mdl_wr && mdl_wa == 2'd1) m_mask = mdl_wd[N-1:0];
            if (mdl_wr && mdl_wa == 2'd2) m_mode = mdl_wd[N-1:0];
            for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = src_irq;
        end
    end

    task automatic bus_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wd,
                            output logic [31:0] rd, output logic [31:0] exp_rd,
                            output int acks, output logic int1, output logic int2);
        @(negedge clk);
        case (idx)
            2'd0:    exp_rd = 32'(m_pend);
            2'd1:    exp_rd = 32'(m_mask);
            2'd2:    exp_rd = 32'(m_mode);
            default: exp_rd = m_int ? m_cause : 32'hFFFF_FFFF;
        endcase
        STB = 1'b1; WE = we;
        ADDR = ($urandom() & 32'hFFFF_FFF3) | {28'd0, idx, 2'b00};
        DAT_I = wd;
        mdl_wr = we; mdl_wa = idx; mdl_wd = wd;
        @(negedge clk);
        STB = 1'b0; WE = 1'b0; mdl_wr = 1'b0;
        rd = DAT_O; acks = ACK ? 1 : 0; int1 = CPU_INT;
        @(negedge clk);
        acks += ACK ? 1 : 0; int2 = CPU_INT;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] d);
        logic [31:0] r, e; int a; logic i1, i2;
        bus_xfer(1'b1, idx, d, r, e, a, i1, i2);
    endtask

    task automatic test_reset();
        logic [31:0] r, e; int a; logic i1, i2;
        rstn = 1'b0; src_irq = 6'h3F;
        repeat (5) @(negedge clk);
        checks++; if (CPU_INT !== 1'b0) begin failures++; $display("FAIL reset_int got=%0b want=0", CPU_INT); end
        checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b want=0", ACK); end
        checks++; if (CPU_CAUSE !== 32'd0 || DAT_O !== 32'd0) begin failures++; $display("FAIL reset_outs cause=%0h dat=%0h want=0", CPU_CAUSE, DAT_O); end
        src_irq = '0; rstn = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus_xfer(1'b0, 2'(k), 32'd0, r, e, a, i1, i2);
            checks++; if (r !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got=%0h want=0", k, r); end
        end
    endtask

    task automatic test_edge_latency();
        logic [31:0] r, e; int a; logic i1, i2; int lat;
        wr(2'd1, 32'h3F); wr(2'd2, 32'h20);
        repeat (6) @(negedge clk);
        src_irq[5] = 1'b1;
        lat = 0;
        for (int ed = 1; ed <= 20 && lat == 0; ed++) begin
            @(posedge clk); #1;
            if (ed == 3) src_irq[5] = 1'b0;
            if (CPU_INT === 1'b1) lat = ed;
        end
        if (src_irq[5]) src_irq[5] = 1'b0;
        checks++; if (lat != 4) begin failures++; $display("FAIL edge_latency got=%0d want=4", lat); end
        checks++; if (CPU_CAUSE !== 32'd5) begin failures++; $display("FAIL edge_cause got=%0d want=5", CPU_CAUSE); end
        repeat (5) @(negedge clk);
        checks++; if (CPU_INT !== 1'b1) begin failures++; $display("FAIL edge_sticky got=%0b want=1", CPU_INT); end
        bus_xfer(1'b1, 2'd0, 32'h20, r, e, a, i1, i2);
        checks++; if (a != 1) begin failures++; $display("FAIL edge_clr_ack got=%0d want=1", a); end
        checks++; if (i1 !== 1'b1 || i2 !== 1'b0) begin failures++; $display("FAIL edge_clr_timing got=%0b%0b want=10", i1, i2); end
    endtask

    task automatic test_priority();
        logic [31:0] r, e; int a; logic i1, i2;
        wr(2'd2, 32'h0); wr(2'd1, 32'h3F);
        src_irq = 6'h18;
        repeat (6) @(negedge clk);
        checks++; if (CPU_INT !== 1'b1 || CPU_CAUSE !== 32'd3) begin failures++; $display("FAIL prio_cause3 got int=%0b cause=%0d want 1/3", CPU_INT, CPU_CAUSE); end
        bus_xfer(1'b0, 2'd3, 32'd0, r, e, a, i1, i2);
        checks++; if (r !== 32'd3) begin failures++; $display("FAIL prio_read3 got=%0h want=3", r); end
        src_irq = 6'h10;
        repeat (6) @(negedge clk);
        checks++; if (CPU_CAUSE !== 32'd4) begin failures++; $display("FAIL prio_cause4 got=%0d want=4", CPU_CAUSE); end
        wr(2'd1, 32'h0);
        bus_xfer(1'b0, 2'd3, 32'd0, r, e, a, i1, i2);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL prio_nocause got=%0h want=ffffffff", r); end
        src_irq = '0;
    endtask

    task automatic test_collision();
        logic [31:0] r, e; int a; logic i1, i2;
        src_irq = '0;
        wr(2'd1, 32'h3F); wr(2'd2, 32'h01);
        repeat (4) @(negedge clk);
        wr(2'd0, 32'h01);
        @(negedge clk); src_irq[0] = 1'b1;
        @(posedge clk); @(posedge clk);
        bus_xfer(1'b1, 2'd0, 32'h01, r, e, a, i1, i2);
        bus_xfer(1'b0, 2'd0, 32'd0, r, e, a, i1, i2);
        checks++; if (r !== 32'h01) begin failures++; $display("FAIL collision_pend got=%0h want=1", r); end
        checks++; if (CPU_INT !== 1'b1 || CPU_CAUSE !== 32'd0) begin failures++; $display("FAIL collision_int got int=%0b cause=%0d want 1/0", CPU_INT, CPU_CAUSE); end
        src_irq = '0;
        wr(2'd2, 32'h0);
        repeat (4) @(negedge clk);
        bus_xfer(1'b0, 2'd0, 32'd0, r, e, a, i1, i2);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL edge_to_level_reload got=%0h want=0", r); end
    endtask

    task automatic test_held_stb();
        int ackc;
        wr(2'd1, 32'h0);
        @(negedge clk);
        STB = 1'b1; WE = 1'b1; ADDR = 32'h4; DAT_I = 32'h15;
        mdl_wr = 1'b1; mdl_wa = 2'd1; mdl_wd = 32'h15;
        ackc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mdl_wr = 1'b0;
            DAT_I = 32'h2A;
            ackc += ACK ? 1 : 0;
        end
        checks++; if (ackc != 1) begin failures++; $display("FAIL held_stb_acks got=%0d want=1", ackc); end
        STB = 1'b0; WE = 1'b0;
        @(negedge clk);
        STB = 1'b1; ADDR = 32'h4;
        @(negedge clk);
        checks++; if (ACK !== 1'b1 || DAT_O !== 32'h15) begin failures++; $display("FAIL held_stb_reack got ack=%0b dat=%0h want 1/15", ACK, DAT_O); end
        STB = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, e; int a; logic i1, i2; int ackc;
        @(negedge clk);
        STB = 1'b1; WE = 1'b1; ADDR = 32'h4; DAT_I = 32'h3F;
        mdl_wr = 1'b1; mdl_wa = 2'd1; mdl_wd = 32'h3F;
        rstn = 1'b0;
        ackc = 0;
        repeat (3) begin @(negedge clk); ackc += ACK ? 1 : 0; end
        STB = 1'b0; WE = 1'b0; mdl_wr = 1'b0;
        rstn = 1'b1;
        repeat (2) begin @(negedge clk); ackc += ACK ? 1 : 0; end
        checks++; if (ackc != 0) begin failures++; $display("FAIL rst_mid_ack got=%0d want=0", ackc); end
        bus_xfer(1'b0, 2'd1, 32'd0, r, e, a, i1, i2);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rst_mid_mask got=%0h want=0", r); end
        @(negedge clk);
        STB = 1'b1; WE = 1'b0; ADDR = 32'h8;
        @(negedge clk);
        checks++; if (ACK !== 1'b1) begin failures++; $display("FAIL rst_async_pre got=%0b want=1", ACK); end
        rstn = 1'b0;
        #1;
        checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL rst_async_drop got=%0b want=0", ACK); end
        STB = 1'b0;
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] r, e, wd; int a; logic i1, i2; logic we; logic [1:0] idx;
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = 2'($urandom_range(0, 3));
                we  = 1'($urandom_range(0, 1));
                wd  = $urandom();
                bus_xfer(we, idx, wd, r, e, a, i1, i2);
                checks++; if (a != 1) begin failures++; $display("FAIL rand_ack it=%0d got=%0d want=1", it, a); end
                if (!we) begin
                    checks++; if (r !== e) begin failures++; $display("FAIL rand_read it=%0d reg=%0d got=%0h want=%0h", it, idx, r, e); end
                end
            end else begin
                @(negedge clk);
                if ($urandom_range(0, 2) == 0) src_irq = 6'($urandom());
            end
            checks++; if (CPU_INT !== m_int || CPU_CAUSE !== m_cause) begin failures++; $display("FAIL rand_out it=%0d got int=%0b cause=%0d want %0b/%0d", it, CPU_INT, CPU_CAUSE, m_int, m_cause); end
        end
        src_irq = '0;
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_collision();
        test_held_stb();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
